// File: rtl/lsq_mem_arbiter.sv
// Single data-memory port sequencer for the memory stage.
// Load misses win over retiring stores unless a store has starved.
module lsq_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [TAG_W-1:0]  ld_tag,
    output logic              ld_ready,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [TAG_W-1:0]  st_tag,
    output logic              st_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ld_done,
    output logic [TAG_W-1:0]  ld_done_tag,
    output logic [DATA_W-1:0] ld_done_data,
    output logic              st_done,
    output logic [TAG_W-1:0]  st_done_tag,
    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_REQ
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic               killed_q, killed_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               ld_done_q, ld_done_d;
    logic [TAG_W-1:0]   ld_done_tag_q, ld_done_tag_d;
    logic [DATA_W-1:0]  ld_done_data_q, ld_done_data_d;
    logic               st_done_q, st_done_d;
    logic [TAG_W-1:0]   st_done_tag_q, st_done_tag_d;

    logic idle;
    logic grant_st;
    logic grant_ld;

    always_comb begin
        idle     = (state_q == IDLE);
        grant_st = st_valid & (!ld_valid | flush |
                   (starve_cnt_q >= CNT_W'(STARVE_LIMIT)));
        grant_ld = ld_valid & !flush & !grant_st;
        ld_ready = idle & grant_ld;
        st_ready = idle & grant_st;
    end

    always_comb begin
        state_d        = state_q;
        starve_cnt_d   = starve_cnt_q;
        killed_d       = killed_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        tag_d          = tag_q;
        ld_done_d      = 1'b0;
        ld_done_tag_d  = ld_done_tag_q;
        ld_done_data_d = ld_done_data_q;
        st_done_d      = 1'b0;
        st_done_tag_d  = st_done_tag_q;

        unique case (state_q)
            IDLE: begin
                killed_d = 1'b0;
                if (grant_st) begin
                    state_d      = ST_REQ;
                    addr_d       = st_addr;
                    wdata_d      = st_data;
                    tag_d        = st_tag;
                    starve_cnt_d = '0;
                end else begin
                    if (st_valid && starve_cnt_q < CNT_W'(STARVE_LIMIT))
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    if (grant_ld) begin
                        state_d = LD_REQ;
                        addr_d  = ld_addr;
                        wdata_d = '0;
                        tag_d   = ld_tag;
                    end
                end
            end
            LD_REQ: begin
                killed_d = killed_q | flush;
                if (mem_gnt)
                    state_d = LD_WAIT;
            end
            LD_WAIT: begin
                killed_d = killed_q | flush;
                if (mem_rvalid) begin
                    state_d  = IDLE;
                    killed_d = 1'b0;
                    // A flush arriving with the data still squashes it
                    if (!(killed_q || flush)) begin
                        ld_done_d      = 1'b1;
                        ld_done_tag_d  = tag_q;
                        ld_done_data_d = mem_rdata;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d       = IDLE;
                    st_done_d     = 1'b1;
                    st_done_tag_d = tag_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            starve_cnt_q   <= '0;
            killed_q       <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            tag_q          <= '0;
            ld_done_q      <= 1'b0;
            ld_done_tag_q  <= '0;
            ld_done_data_q <= '0;
            st_done_q      <= 1'b0;
            st_done_tag_q  <= '0;
        end else begin
            state_q        <= state_d;
            starve_cnt_q   <= starve_cnt_d;
            killed_q       <= killed_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            tag_q          <= tag_d;
            ld_done_q      <= ld_done_d;
            ld_done_tag_q  <= ld_done_tag_d;
            ld_done_data_q <= ld_done_data_d;
            st_done_q      <= st_done_d;
            st_done_tag_q  <= st_done_tag_d;
        end
    end

    always_comb begin
        mem_req      = (state_q == LD_REQ) || (state_q == ST_REQ);
        mem_we       = (state_q == ST_REQ);
        mem_addr     = mem_req ? addr_q : '0;
        mem_wdata    = mem_we ? wdata_q : '0;
        busy         = !idle;
        ld_done      = ld_done_q;
        ld_done_tag  = ld_done_tag_q;
        ld_done_data = ld_done_data_q;
        st_done      = st_done_q;
        st_done_tag  = st_done_tag_q;
    end

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Directed bench for lsq_mem_arbiter; completions are checked by a
// scoreboard monitor against expectations queued at accept time.
module tb_lsq_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_tag = '0;
    logic        ld_ready;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [31:0] st_tag = '0;
    logic        st_ready;
    logic        flush = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ld_done;
    logic [31:0] ld_done_tag;
    logic [31:0] ld_done_data;
    logic        st_done;
    logic [31:0] st_done_tag;
    logic        busy;

    lsq_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_tag       (ld_tag),
        .ld_ready     (ld_ready),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_tag       (st_tag),
        .st_ready     (st_ready),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .ld_done      (ld_done),
        .ld_done_tag  (ld_done_tag),
        .ld_done_data (ld_done_data),
        .st_done      (st_done),
        .st_done_tag  (st_done_tag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ld;
        logic [31:0] tag;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic push(input bit is_ld, input logic [31:0] tag,
                        input logic [31:0] data, input int when);
        exp_t e;
        e.is_ld = is_ld;
        e.tag   = tag;
        e.data  = data;
        e.cyc   = when;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard monitor: every completion pulse must match the queue head
    always @(negedge clk) begin
        if (!reset && (ld_done || st_done)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: ld=%0b st=%0b expected none (cycle %0d)",
                         ld_done, st_done, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_kind", {31'b0, ld_done}, {31'b0, e.is_ld});
                chk("done_cycle", cyc, e.cyc);
                if (e.is_ld) begin
                    chk("ld_done_tag", ld_done_tag, e.tag);
                    chk("ld_done_data", ld_done_data, e.data);
                end else begin
                    chk("st_done_tag", st_done_tag, e.tag);
                end
            end
        end
    end

    logic [14:0] ld_pat;
    logic [14:0] st_pat;

    initial begin
        // Reset state
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_ld_done_tag", ld_done_tag, 32'd0);
        chk("rst_st_done", {31'b0, st_done}, 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // 1: minimum-latency load
        ld_valid = 1'b1; ld_addr = 32'h40; ld_tag = 32'd5;
        settle();
        chk("t1_ld_ready", {31'b0, ld_ready}, 32'd1);
        push(1'b1, 32'd5, 32'hDEAD, cyc + 3);
        tick();
        ld_valid = 1'b0; mem_gnt = 1'b1;
        settle();
        chk("t1_mem_req", {31'b0, mem_req}, 32'd1);
        chk("t1_mem_we", {31'b0, mem_we}, 32'd0);
        chk("t1_mem_addr", mem_addr, 32'h40);
        chk("t1_mem_wdata", mem_wdata, 32'd0);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        settle();
        chk("t1_wait_req", {31'b0, mem_req}, 32'd0);
        chk("t1_wait_busy", {31'b0, busy}, 32'd1);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t1_idle", {31'b0, busy}, 32'd0);
        tick();

        // 2: store with grant delayed four cycles
        st_valid = 1'b1; st_addr = 32'h80; st_data = 32'h1234; st_tag = 32'd7;
        settle();
        chk("t2_st_ready", {31'b0, st_ready}, 32'd1);
        push(1'b0, 32'd7, 32'd0, cyc + 6);
        tick();
        st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
        for (int i = 0; i < 5; i++) begin
            mem_gnt = (i == 4);
            settle();
            chk("t2_req", {31'b0, mem_req}, 32'd1);
            chk("t2_we", {31'b0, mem_we}, 32'd1);
            chk("t2_addr", mem_addr, 32'h80);
            chk("t2_wdata", mem_wdata, 32'h1234);
            tick();
        end
        mem_gnt = 1'b0;
        tick();

        // 3: starvation guard with both requesters held high
        ld_valid = 1'b1; ld_tag = 32'd10; ld_addr = 32'h100;
        st_valid = 1'b1; st_tag = 32'd20; st_addr = 32'h200; st_data = 32'h9;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA0;
        ld_pat = 15'h4249;
        st_pat = 15'h1000;
        for (int k = 0; k < 15; k++) begin
            settle();
            chk("t3_ld_ready", {31'b0, ld_ready}, {31'b0, ld_pat[k]});
            chk("t3_st_ready", {31'b0, st_ready}, {31'b0, st_pat[k]});
            if (ld_pat[k]) push(1'b1, 32'd10, 32'hA0, cyc + 3);
            if (st_pat[k]) push(1'b0, 32'd20, 32'd0, cyc + 2);
            tick();
        end
        ld_valid = 1'b0; st_valid = 1'b0;
        tick();
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();

        // 4: flush in LD_WAIT kills the load, next load is normal
        ld_valid = 1'b1; ld_addr = 32'h44; ld_tag = 32'd3;
        settle();
        chk("t4_ld_ready", {31'b0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; flush = 1'b1;
        settle();
        chk("t4_busy_wait", {31'b0, busy}, 32'd1);
        tick();
        flush = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t4_busy_drop", {31'b0, busy}, 32'd0);
        chk("t4_no_done", {31'b0, ld_done}, 32'd0);
        ld_valid = 1'b1; ld_addr = 32'h48; ld_tag = 32'd4;
        settle();
        chk("t4_next_ready", {31'b0, ld_ready}, 32'd1);
        push(1'b1, 32'd4, 32'hBEEF, cyc + 3);
        tick();
        ld_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF;
        tick();
        mem_rvalid = 1'b0;
        tick();

        // 5: asynchronous reset while in LD_WAIT
        ld_valid = 1'b1; ld_addr = 32'h4C; ld_tag = 32'd9;
        settle();
        chk("t5_ld_ready", {31'b0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        settle();
        chk("t5_busy_wait", {31'b0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_busy", {31'b0, busy}, 32'd0);
        chk("t5_rst_addr", mem_addr, 32'd0);
        chk("t5_rst_ld_tag", ld_done_tag, 32'd0);
        chk("t5_rst_ld_data", ld_done_data, 32'd0);
        chk("t5_rst_st_tag", st_done_tag, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        settle();
        chk("t5_idle_rvalid", {31'b0, busy}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t5_no_done", {31'b0, ld_done}, 32'd0);
        tick();

        // 6: flush in IDLE blocks loads, never stores
        flush = 1'b1; ld_valid = 1'b1; ld_addr = 32'h50; ld_tag = 32'd11;
        settle();
        chk("t6_ld_blocked", {31'b0, ld_ready}, 32'd0);
        st_valid = 1'b1; st_addr = 32'h90; st_data = 32'h5A; st_tag = 32'd30;
        settle();
        chk("t6_st_ready", {31'b0, st_ready}, 32'd1);
        chk("t6_ld_ready", {31'b0, ld_ready}, 32'd0);
        push(1'b0, 32'd30, 32'd0, cyc + 2);
        tick();
        flush = 1'b0; ld_valid = 1'b0; st_valid = 1'b0; mem_gnt = 1'b1;
        settle();
        chk("t6_mem_we", {31'b0, mem_we}, 32'd1);
        chk("t6_mem_wdata", mem_wdata, 32'h5A);
        tick();
        mem_gnt = 1'b0;
        tick();
        tick();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
